qdr2p_b4_sched: RTL and testbench



---
 rtl/qdr2p_pkg.sv | 16 +
 rtl/qdr2p_rd_capture.sv | 36 +++
 rtl/qdr2p_b4_sched.sv | 126 ++++++++++++
 tb/tb_qdr2p_b4_sched.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/qdr2p_pkg.sv
// Shared constants and slot encoding for the QDR II+ burst-of-4 scheduler.
package qdr2p_pkg;

  localparam int unsigned QDR_BEAT_W  = 36;
  localparam int unsigned QDR_BURST   = 4;
  localparam int unsigned QDR_BWS_W   = 4;
  localparam int unsigned QDR_BURST_W = QDR_BEAT_W * QDR_BURST;

  localparam logic [QDR_BWS_W-1:0] QDR_BWS_IDLE = '1;

  typedef enum logic {
    SLOT_RD = 1'b0,
    SLOT_WR = 1'b1
  } slot_e;

endpackage

// File: rtl/qdr2p_rd_capture.sv
// Tracks issued reads through the fixed PHY latency and reassembles the
// four returned beats into one response word.
module qdr2p_rd_capture #(
  parameter int unsigned DATA_W = 36,
  parameter int unsigned RD_LAT = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rd_issue,
  input  logic [DATA_W-1:0]   q_rise,
  input  logic [DATA_W-1:0]   q_fall,
  output logic                rsp_valid,
  output logic [4*DATA_W-1:0] rsp_data
);

  logic [RD_LAT+1:0]   issue_sr;
  logic [2*DATA_W-1:0] lo_beats;

  // Beats 2/3 go straight into the response word so valid lands at t+3+RD_LAT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      issue_sr  <= '0;
      lo_beats  <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      issue_sr  <= {issue_sr[RD_LAT:0], rd_issue};
      if (issue_sr[RD_LAT])
        lo_beats <= {q_fall, q_rise};
      rsp_valid <= issue_sr[RD_LAT+1];
      if (issue_sr[RD_LAT+1])
        rsp_data <= {q_fall, q_rise, lo_beats};
    end
  end

endmodule

// File: rtl/qdr2p_b4_sched.sv
// QDR II+ B4 command scheduler: alternating read/write address slots, write
// beat serializer with byte strobes, and read response reassembly.
module qdr2p_b4_sched
  import qdr2p_pkg::*;
#(
  parameter int unsigned ADDR_W = 18,
  parameter int unsigned DATA_W = QDR_BEAT_W,
  parameter int unsigned RD_LAT = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              cal_done,
  input  logic                              rd_req_valid,
  output logic                              rd_req_ready,
  input  logic [ADDR_W-1:0]                 rd_req_addr,
  input  logic                              wr_req_valid,
  output logic                              wr_req_ready,
  input  logic [ADDR_W-1:0]                 wr_req_addr,
  input  logic [4*DATA_W-1:0]               wr_req_data,
  input  logic [QDR_BURST*QDR_BWS_W-1:0]    wr_req_bw_n,
  output logic                              rd_rsp_valid,
  output logic [4*DATA_W-1:0]               rd_rsp_data,
  output logic                              qdr_rps_n,
  output logic                              qdr_wps_n,
  output logic [ADDR_W-1:0]                 qdr_sa,
  output logic [DATA_W-1:0]                 qdr_d_rise,
  output logic [DATA_W-1:0]                 qdr_d_fall,
  output logic [QDR_BWS_W-1:0]              qdr_bws_rise_n,
  output logic [QDR_BWS_W-1:0]              qdr_bws_fall_n,
  input  logic [DATA_W-1:0]                 qdr_q_rise,
  input  logic [DATA_W-1:0]                 qdr_q_fall
);

  slot_e ph, ph_next;
  logic  rd_fire, wr_fire;

  logic [4*DATA_W-1:0]               wr_buf;
  logic [QDR_BURST*QDR_BWS_W-1:0]    wr_bw_buf;
  logic                              wr_pend;
  logic [2*DATA_W-1:0]               wr_hi;
  logic [2*QDR_BWS_W-1:0]            wr_hi_bw;
  logic                              wr_hi_pend;

  always_comb begin
    ph_next = SLOT_RD;
    if (cal_done)
      ph_next = (ph == SLOT_RD) ? SLOT_WR : SLOT_RD;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ph <= SLOT_RD;
    else        ph <= ph_next;
  end

  assign rd_req_ready = rst_n && cal_done && (ph == SLOT_RD);
  assign wr_req_ready = rst_n && cal_done && (ph == SLOT_WR);
  assign rd_fire      = rd_req_valid && rd_req_ready;
  assign wr_fire      = wr_req_valid && wr_req_ready;

  // wr_buf takes the next write while wr_hi still holds beats 2/3 of the
  // previous one, so back-to-back writes stream without a data-bus gap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      qdr_rps_n      <= 1'b1;
      qdr_wps_n      <= 1'b1;
      qdr_sa         <= '0;
      qdr_d_rise     <= '0;
      qdr_d_fall     <= '0;
      qdr_bws_rise_n <= QDR_BWS_IDLE;
      qdr_bws_fall_n <= QDR_BWS_IDLE;
      wr_buf         <= '0;
      wr_bw_buf      <= '1;
      wr_pend        <= 1'b0;
      wr_hi          <= '0;
      wr_hi_bw       <= '1;
      wr_hi_pend     <= 1'b0;
    end else begin
      qdr_rps_n <= !rd_fire;
      qdr_wps_n <= !wr_fire;
      if (rd_fire)
        qdr_sa <= rd_req_addr;
      else if (wr_fire)
        qdr_sa <= wr_req_addr;

      wr_pend <= wr_fire;
      if (wr_fire) begin
        wr_buf    <= wr_req_data;
        wr_bw_buf <= wr_req_bw_n;
      end

      wr_hi_pend <= wr_pend;
      if (wr_pend) begin
        qdr_d_rise     <= wr_buf[DATA_W-1:0];
        qdr_d_fall     <= wr_buf[2*DATA_W-1:DATA_W];
        qdr_bws_rise_n <= wr_bw_buf[QDR_BWS_W-1:0];
        qdr_bws_fall_n <= wr_bw_buf[2*QDR_BWS_W-1:QDR_BWS_W];
        wr_hi          <= wr_buf[4*DATA_W-1:2*DATA_W];
        wr_hi_bw       <= wr_bw_buf[4*QDR_BWS_W-1:2*QDR_BWS_W];
      end else if (wr_hi_pend) begin
        qdr_d_rise     <= wr_hi[DATA_W-1:0];
        qdr_d_fall     <= wr_hi[2*DATA_W-1:DATA_W];
        qdr_bws_rise_n <= wr_hi_bw[QDR_BWS_W-1:0];
        qdr_bws_fall_n <= wr_hi_bw[2*QDR_BWS_W-1:QDR_BWS_W];
      end else begin
        qdr_d_rise     <= '0;
        qdr_d_fall     <= '0;
        qdr_bws_rise_n <= QDR_BWS_IDLE;
        qdr_bws_fall_n <= QDR_BWS_IDLE;
      end
    end
  end

  qdr2p_rd_capture #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_capture (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_issue  (rd_fire),
    .q_rise    (qdr_q_rise),
    .q_fall    (qdr_q_fall),
    .rsp_valid (rd_rsp_valid),
    .rsp_data  (rd_rsp_data)
  );

endmodule

// File: tb/tb_qdr2p_b4_sched.sv
// Bench for qdr2p_b4_sched: three latency variants driven in lockstep and
// checked cycle by cycle against a slot/latency timeline model.
module tb_qdr2p_b4_sched;

  localparam int unsigned AW   = 18;
  localparam int unsigned DW   = 36;
  localparam int unsigned NI   = 3;
  localparam int unsigned MAXC = 1024;

  function automatic int unsigned lat_of(input int unsigned i);
    return (i == 0) ? 8 : ((i == 1) ? 2 : 31);
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n, cal_done, rd_req_valid, wr_req_valid;
  logic [AW-1:0]   rd_req_addr, wr_req_addr;
  logic [4*DW-1:0] wr_req_data;
  logic [15:0]     wr_req_bw_n;
  logic [DW-1:0]   qdr_q_rise, qdr_q_fall;

  logic            rrdy_o [NI];
  logic            wrdy_o [NI];
  logic            rv_o   [NI];
  logic [4*DW-1:0] rd_o   [NI];
  logic            rps_o  [NI];
  logic            wps_o  [NI];
  logic [AW-1:0]   sa_o   [NI];
  logic [DW-1:0]   dr_o   [NI];
  logic [DW-1:0]   df_o   [NI];
  logic [3:0]      br_o   [NI];
  logic [3:0]      bf_o   [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    qdr2p_b4_sched #(
      .ADDR_W (AW),
      .DATA_W (DW),
      .RD_LAT (lat_of(g))
    ) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .cal_done       (cal_done),
      .rd_req_valid   (rd_req_valid),
      .rd_req_ready   (rrdy_o[g]),
      .rd_req_addr    (rd_req_addr),
      .wr_req_valid   (wr_req_valid),
      .wr_req_ready   (wrdy_o[g]),
      .wr_req_addr    (wr_req_addr),
      .wr_req_data    (wr_req_data),
      .wr_req_bw_n    (wr_req_bw_n),
      .rd_rsp_valid   (rv_o[g]),
      .rd_rsp_data    (rd_o[g]),
      .qdr_rps_n      (rps_o[g]),
      .qdr_wps_n      (wps_o[g]),
      .qdr_sa         (sa_o[g]),
      .qdr_d_rise     (dr_o[g]),
      .qdr_d_fall     (df_o[g]),
      .qdr_bws_rise_n (br_o[g]),
      .qdr_bws_fall_n (bf_o[g]),
      .qdr_q_rise     (qdr_q_rise),
      .qdr_q_fall     (qdr_q_fall)
    );
  end

  // Expected pin/response timeline, indexed by cycle.
  logic            e_rps    [MAXC];
  logic            e_wps    [MAXC];
  logic            e_sa_set [MAXC];
  logic [AW-1:0]   e_sa     [MAXC];
  logic [DW-1:0]   e_dr     [MAXC];
  logic [DW-1:0]   e_df     [MAXC];
  logic [3:0]      e_br     [MAXC];
  logic [3:0]      e_bf     [MAXC];
  logic            e_rv     [NI][MAXC];
  logic            e_rdchk  [NI][MAXC];
  logic [4*DW-1:0] e_rd     [NI][MAXC];

  int unsigned n_chk, n_err, cyc, armed_from;
  int unsigned rd_acc_n, wr_acc_n, rps_lo_n, wps_lo_n;
  logic        ph_m;
  logic [AW-1:0] sa_m;
  logic        last_rd_acc, last_wr_acc;

  task automatic check_eq(input string tag, input logic [143:0] got, input logic [143:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] beat(input int unsigned c, input logic f);
    logic [26:0] cc;
    cc = c[26:0];
    return {8'hC3, cc, f};
  endfunction

  task automatic set_idle(input int unsigned i);
    e_rps[i] = 1'b1; e_wps[i] = 1'b1; e_sa_set[i] = 1'b0; e_sa[i] = '0;
    e_dr[i] = '0; e_df[i] = '0; e_br[i] = 4'hF; e_bf[i] = 4'hF;
    for (int unsigned k = 0; k < NI; k++) begin
      e_rv[k][i] = 1'b0; e_rdchk[k][i] = 1'b0; e_rd[k][i] = '0;
    end
  endtask

  task automatic rand_req();
    logic [159:0] tmp;
    tmp = {$urandom, $urandom, $urandom, $urandom, $urandom};
    rd_req_addr = AW'($urandom);
    wr_req_addr = AW'($urandom);
    wr_req_data = tmp[4*DW-1:0];
    wr_req_bw_n = 16'($urandom);
  endtask

  task automatic check_outputs();
    if (cyc < armed_from) return;
    if (e_sa_set[cyc]) sa_m = e_sa[cyc];
    if (rps_o[0] == 1'b0) rps_lo_n++;
    if (wps_o[0] == 1'b0) wps_lo_n++;
    for (int unsigned k = 0; k < NI; k++) begin
      check_eq($sformatf("rps_n[%0d]", k), rps_o[k], e_rps[cyc]);
      check_eq($sformatf("wps_n[%0d]", k), wps_o[k], e_wps[cyc]);
      check_eq($sformatf("sa[%0d]", k), sa_o[k], sa_m);
      check_eq($sformatf("d_rise[%0d]", k), dr_o[k], e_dr[cyc]);
      check_eq($sformatf("d_fall[%0d]", k), df_o[k], e_df[cyc]);
      check_eq($sformatf("bws_rise[%0d]", k), br_o[k], e_br[cyc]);
      check_eq($sformatf("bws_fall[%0d]", k), bf_o[k], e_bf[cyc]);
      check_eq($sformatf("rsp_valid[%0d]", k), rv_o[k], e_rv[k][cyc]);
      if (e_rdchk[k][cyc])
        check_eq($sformatf("rsp_data[%0d]", k), rd_o[k], e_rd[k][cyc]);
    end
  endtask

  // One clock cycle: check outputs, apply inputs, advance the model.
  task automatic step(input logic r, input logic c, input logic rv, input logic wv);
    logic rrdy, wrdy;
    int unsigned t, l;
    if (cyc + 40 >= MAXC) begin
      $display("FAIL cycle_budget cycle=%0d limit=%0d", cyc, MAXC);
      $fatal(1);
    end
    check_outputs();
    rst_n = r; cal_done = c; rd_req_valid = rv; wr_req_valid = wv;
    qdr_q_rise = beat(cyc, 1'b0);
    qdr_q_fall = beat(cyc, 1'b1);
    #1;
    rrdy = r && c && !ph_m;
    wrdy = r && c && ph_m;
    if (cyc >= armed_from) begin
      for (int unsigned k = 0; k < NI; k++) begin
        check_eq($sformatf("rd_ready[%0d]", k), rrdy_o[k], rrdy);
        check_eq($sformatf("wr_ready[%0d]", k), wrdy_o[k], wrdy);
      end
    end
    last_rd_acc = rv && rrdy;
    last_wr_acc = wv && wrdy;
    t = cyc;
    if (!r) begin
      for (int unsigned i = t + 1; i < MAXC; i++) set_idle(i);
      e_sa_set[t+1] = 1'b1;
      for (int unsigned k = 0; k < NI; k++) e_rdchk[k][t+1] = 1'b1;
      if (armed_from > t) armed_from = t + 1;
    end
    if (last_rd_acc) begin
      rd_acc_n++;
      e_rps[t+1] = 1'b0; e_sa_set[t+1] = 1'b1; e_sa[t+1] = rd_req_addr;
      for (int unsigned k = 0; k < NI; k++) begin
        l = lat_of(k);
        e_rv[k][t+3+l]    = 1'b1;
        e_rdchk[k][t+3+l] = 1'b1;
        e_rd[k][t+3+l]    = {beat(t+2+l, 1'b1), beat(t+2+l, 1'b0),
                             beat(t+1+l, 1'b1), beat(t+1+l, 1'b0)};
      end
    end
    if (last_wr_acc) begin
      wr_acc_n++;
      e_wps[t+1] = 1'b0; e_sa_set[t+1] = 1'b1; e_sa[t+1] = wr_req_addr;
      e_dr[t+2] = wr_req_data[DW-1:0];      e_df[t+2] = wr_req_data[2*DW-1:DW];
      e_br[t+2] = wr_req_bw_n[3:0];         e_bf[t+2] = wr_req_bw_n[7:4];
      e_dr[t+3] = wr_req_data[3*DW-1:2*DW]; e_df[t+3] = wr_req_data[4*DW-1:3*DW];
      e_br[t+3] = wr_req_bw_n[11:8];        e_bf[t+3] = wr_req_bw_n[15:12];
    end
    ph_m = (r && c) ? !ph_m : 1'b0;
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    n_chk = 0; n_err = 0; cyc = 0; armed_from = MAXC;
    rd_acc_n = 0; wr_acc_n = 0; rps_lo_n = 0; wps_lo_n = 0;
    ph_m = 1'b0; sa_m = '0; last_rd_acc = 1'b0; last_wr_acc = 1'b0;
    for (int unsigned i = 0; i < MAXC; i++) set_idle(i);
    rst_n = 1'b0; cal_done = 1'b1; rd_req_valid = 1'b0; wr_req_valid = 1'b0;
    qdr_q_rise = '0; qdr_q_fall = '0;
    rand_req();
    @(negedge clk);

    // Reset with requests pending, then calibration still low.
    repeat (3) step(1'b0, 1'b1, 1'b1, 1'b1);
    repeat (3) step(1'b1, 1'b0, 1'b1, 1'b1);

    // Single read right as cal_done rises (must land in a read slot).
    rd_req_addr = 18'h00123;
    step(1'b1, 1'b1, 1'b1, 1'b0);
    repeat (14) step(1'b1, 1'b1, 1'b0, 1'b0);

    // Single write with mixed byte enables.
    wr_req_addr = 18'h3FFFF;
    wr_req_data = {36'd4, 36'd3, 36'd2, 36'd1};
    wr_req_bw_n = 16'hF0F0;
    last_wr_acc = 1'b0;
    for (int j = 0; j < 4 && !last_wr_acc; j++) step(1'b1, 1'b1, 1'b0, 1'b1);
    repeat (5) step(1'b1, 1'b1, 1'b0, 1'b0);

    // Both streams continuously valid for 100 cycles.
    for (int j = 0; j < 100; j++) begin
      rand_req();
      step(1'b1, 1'b1, 1'b1, 1'b1);
    end
    repeat (10) step(1'b1, 1'b1, 1'b0, 1'b0);

    // cal_done drops one cycle after a write accept.
    rand_req();
    last_wr_acc = 1'b0;
    for (int j = 0; j < 4 && !last_wr_acc; j++) step(1'b1, 1'b1, 1'b0, 1'b1);
    repeat (4) step(1'b1, 1'b0, 1'b1, 1'b1);
    repeat (6) step(1'b1, 1'b1, 1'b1, 1'b1);
    repeat (10) step(1'b1, 1'b1, 1'b0, 1'b0);

    // One-cycle reset two cycles after a read accept.
    rand_req();
    last_rd_acc = 1'b0;
    for (int j = 0; j < 4 && !last_rd_acc; j++) step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (40) step(1'b1, 1'b1, 1'b0, 1'b0);

    // Random traffic with occasional calibration loss and reset.
    for (int j = 0; j < 380; j++) begin
      rand_req();
      step(($urandom % 60) != 0, ($urandom % 10) != 0, 1'($urandom), 1'($urandom));
    end
    repeat (4) step(1'b1, 1'b1, 1'b0, 1'b0);

    // 16 back-to-back reads across all three latency variants.
    for (int j = 0; j < 32; j++) begin
      rand_req();
      step(1'b1, 1'b1, 1'b1, 1'b0);
    end
    repeat (45) step(1'b1, 1'b1, 1'b0, 1'b0);

    check_eq("rps_low_count", 144'(rps_lo_n), 144'(rd_acc_n));
    check_eq("wps_low_count", 144'(wps_lo_n), 144'(wr_acc_n));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
